// File: rtl/encoder8_3_serial.sv
// Serial multi-hot to binary encoder: one index per output handshake.
// Emits lowest or highest set bit first, selected by LSB_FIRST.
module encoder8_3_serial #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 3,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_err,
  output logic             busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] sel;
  logic [IDX_W-1:0] idx;
  logic             solo;
  logic             ready_q;
  logic             zero_q;
  logic             in_hs;
  logic             out_hs;

  // Later loop iterations win, so scan order picks the priority end.
  always_comb begin
    idx = '0;
    sel = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending[i]) begin
          idx = IDX_W'(i);
          sel = WIDTH'(1) << i;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending[i]) begin
          idx = IDX_W'(i);
          sel = WIDTH'(1) << i;
        end
      end
    end
  end

  assign solo = (pending != '0) &&
                ((pending & (pending - WIDTH'(1))) == '0);

  assign in_ready  = ready_q;
  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign out_idx   = idx;
  assign out_last  = out_valid && solo;
  assign zero_err  = zero_q;

  assign in_hs  = in_valid && ready_q;
  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      ready_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      zero_q <= 1'b0;
      unique case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (in_hs) begin
            if (in_vec != '0) begin
              pending <= in_vec;
              state   <= EMIT;
              ready_q <= 1'b0;
            end else begin
              zero_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_hs) begin
            pending <= pending & ~sel;
            if (solo) begin
              state   <= IDLE;
              ready_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder8_3_serial.sv
// Directed bench for encoder8_3_serial.
// Runs LSB-first and MSB-first instances side by side on shared inputs.
module tb_encoder8_3_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       out_ready;

  logic       l_in_ready, l_out_valid, l_out_last, l_zero_err, l_busy;
  logic [2:0] l_out_idx;
  logic       m_in_ready, m_out_valid, m_out_last, m_zero_err, m_busy;
  logic [2:0] m_out_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder8_3_serial #(.WIDTH(8), .IDX_W(3), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(l_in_ready), .in_vec(in_vec),
    .out_valid(l_out_valid), .out_ready(out_ready),
    .out_idx(l_out_idx), .out_last(l_out_last),
    .zero_err(l_zero_err), .busy(l_busy)
  );

  encoder8_3_serial #(.WIDTH(8), .IDX_W(3), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(m_in_ready), .in_vec(in_vec),
    .out_valid(m_out_valid), .out_ready(out_ready),
    .out_idx(m_out_idx), .out_last(m_out_last),
    .zero_err(m_zero_err), .busy(m_busy)
  );

  typedef struct {
    logic [7:0] vec;
    int         n;
    int         lsb[8];
    int         msb[8];
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " l_out_valid"}, int'(l_out_valid), 0);
    chk({tag, " m_out_valid"}, int'(m_out_valid), 0);
    chk({tag, " l_in_ready"}, int'(l_in_ready), 1);
    chk({tag, " m_in_ready"}, int'(m_in_ready), 1);
    chk({tag, " l_busy"}, int'(l_busy), 0);
  endtask

  // Wait (bounded) until both instances report ready, then handshake vec.
  task automatic send(input logic [7:0] v);
    int k;
    k = 0;
    while (!(l_in_ready && m_in_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("send ready timeout", int'(l_in_ready && m_in_ready), 1);
    in_valid = 1'b1;
    in_vec   = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = 8'h5A;
  endtask

  initial begin
    tbl[0] = '{vec: 8'h01, n: 1, lsb: '{0,0,0,0,0,0,0,0},
               msb: '{0,0,0,0,0,0,0,0}};
    tbl[1] = '{vec: 8'hA6, n: 4, lsb: '{1,2,5,7,0,0,0,0},
               msb: '{7,5,2,1,0,0,0,0}};
    tbl[2] = '{vec: 8'h81, n: 2, lsb: '{0,7,0,0,0,0,0,0},
               msb: '{7,0,0,0,0,0,0,0}};
    tbl[3] = '{vec: 8'h80, n: 1, lsb: '{7,0,0,0,0,0,0,0},
               msb: '{7,0,0,0,0,0,0,0}};
    tbl[4] = '{vec: 8'h3C, n: 4, lsb: '{2,3,4,5,0,0,0,0},
               msb: '{5,4,3,2,0,0,0,0}};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = 8'h00;
    out_ready = 1'b1;
    #1;
    chk("rst out_valid", int'(l_out_valid), 0);
    chk("rst out_idx", int'(l_out_idx), 0);
    chk("rst out_last", int'(l_out_last), 0);
    chk("rst zero_err", int'(l_zero_err), 0);
    chk("rst busy", int'(m_busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel in_ready pre-edge", int'(l_in_ready), 0);
    @(negedge clk);
    chk_idle("post-rst");

    // Table: full drain with out_ready held high.
    for (int t = 0; t < 5; t++) begin
      send(tbl[t].vec);
      for (int b = 0; b < tbl[t].n; b++) begin
        chk($sformatf("v%0d b%0d l_valid", t, b), int'(l_out_valid), 1);
        chk($sformatf("v%0d b%0d l_idx", t, b), int'(l_out_idx),
            tbl[t].lsb[b]);
        chk($sformatf("v%0d b%0d m_idx", t, b), int'(m_out_idx),
            tbl[t].msb[b]);
        chk($sformatf("v%0d b%0d l_last", t, b), int'(l_out_last),
            int'(b == tbl[t].n - 1));
        chk($sformatf("v%0d b%0d m_last", t, b), int'(m_out_last),
            int'(b == tbl[t].n - 1));
        chk($sformatf("v%0d b%0d in_ready", t, b), int'(l_in_ready), 0);
        chk($sformatf("v%0d b%0d busy", t, b), int'(m_busy), 1);
        @(negedge clk);
      end
      chk_idle($sformatf("v%0d end", t));
    end

    // 8'hFF with out_ready toggling: each index holds through stalls.
    begin
      int cnt;
      int cyc;
      send(8'hFF);
      cnt = 0;
      cyc = 0;
      while (cnt < 8 && cyc < 40) begin
        out_ready = (cyc % 2 == 0);
        #1;
        chk($sformatf("ff c%0d l_idx", cyc), int'(l_out_idx), cnt);
        chk($sformatf("ff c%0d m_idx", cyc), int'(m_out_idx), 7 - cnt);
        chk($sformatf("ff c%0d last", cyc), int'(l_out_last),
            int'(cnt == 7));
        chk($sformatf("ff c%0d in_ready", cyc), int'(l_in_ready), 0);
        if (l_out_valid && out_ready) cnt++;
        cyc++;
        @(negedge clk);
      end
      chk("ff handshakes", cnt, 8);
      chk("ff cycles", cyc, 15);
      out_ready = 1'b1;
      chk_idle("ff end");
    end

    // All-zero vector: one-cycle zero_err, no output.
    send(8'h00);
    chk("zero l_err", int'(l_zero_err), 1);
    chk("zero m_err", int'(m_zero_err), 1);
    chk_idle("zero");
    @(negedge clk);
    chk("zero err clears", int'(l_zero_err), 0);
    chk("zero no valid", int'(l_out_valid), 0);

    // Reset mid-EMIT after two indices of 8'hC3.
    send(8'hC3);
    chk("c3 b0 l_idx", int'(l_out_idx), 0);
    chk("c3 b0 m_idx", int'(m_out_idx), 7);
    @(negedge clk);
    chk("c3 b1 l_idx", int'(l_out_idx), 1);
    chk("c3 b1 m_idx", int'(m_out_idx), 6);
    @(negedge clk);
    chk("c3 b2 l_idx", int'(l_out_idx), 6);
    rst = 1'b1;
    #1;
    chk("midrst l_valid", int'(l_out_valid), 0);
    chk("midrst m_valid", int'(m_out_valid), 0);
    chk("midrst busy", int'(l_busy), 0);
    chk("midrst in_ready", int'(l_in_ready), 0);
    chk("midrst last", int'(l_out_last), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("after midrst");
    send(8'h10);
    chk("h10 l_idx", int'(l_out_idx), 4);
    chk("h10 m_idx", int'(m_out_idx), 4);
    chk("h10 l_last", int'(l_out_last), 1);
    chk("h10 m_last", int'(m_out_last), 1);
    @(negedge clk);
    chk_idle("h10 end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
